// File: rtl/debounce_pkg.sv
// Shared constants, channel state encoding and elaboration helpers for debounce_bank.
package debounce_pkg;

    localparam int DEF_SYNC_STAGES              = 2;
    localparam int DEF_STABLE_CYCLES_50MHZ_10MS = 500000;

    typedef enum logic {
        DB_IDLE  = 1'b0,
        DB_COUNT = 1'b1
    } db_state_e;

    // Ceiling log2; used only for parameter range checks.
    function automatic int clog2(input longint unsigned v);
        int r;
        r = 0;
        for (int i = 0; i < 63; i++) begin
            if ((64'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: synchroniser, stability counter, registered level and edge strobes.
// Optional long-press strobe when DEBOUNCE_LONG_PRESS_EN is defined.
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int   SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int   CNT_W         = 20,
    parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES_50MHZ_10MS,
`ifdef DEBOUNCE_LONG_PRESS_EN
    parameter int   LONG_CYCLES   = (1 << CNT_W) - 1,
`endif
    parameter logic RST_BIT       = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic sig_i,
`ifdef DEBOUNCE_LONG_PRESS_EN
    output logic long_o,
`endif
    output logic sig_o,
    output logic rise_o,
    output logic fall_o,
    output logic busy_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    db_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   out_q, out_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            DB_IDLE: begin
                if (s != out_q) begin
                    state_d = DB_COUNT;
                    cnt_d   = CNT_W'(1);
                end
            end
            DB_COUNT: begin
                if (s == out_q) begin
                    // Bounced back before the window closed: abandon silently.
                    state_d = DB_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    state_d = DB_IDLE;
                    cnt_d   = '0;
                    out_d   = s;
                    rise_d  = s;
                    fall_d  = ~s;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = DB_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= {SYNC_STAGES{RST_BIT}};
            state_q <= DB_IDLE;
            cnt_q   <= '0;
            out_q   <= RST_BIT;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign sig_o  = out_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;
    // Next-state view so the top's registered OR lines up with state_q.
    assign busy_o = (state_d == DB_COUNT);

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES);

    logic [CNT_W-1:0] lcnt_q, lcnt_d;
    logic             long_q, long_d;

    // Counter parks at LONG_LAST so the strobe fires once per high period.
    always_comb begin
        lcnt_d = lcnt_q;
        long_d = 1'b0;
        if (!(out_q && out_d)) begin
            lcnt_d = '0;
        end else if (lcnt_q != LONG_LAST) begin
            lcnt_d = lcnt_q + 1'b1;
            long_d = (lcnt_d == LONG_LAST);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lcnt_q <= '0;
            long_q <= 1'b0;
        end else begin
            lcnt_q <= lcnt_d;
            long_q <= long_d;
        end
    end

    assign long_o = long_q;
`endif

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel counter-based debouncer with rise/fall strobes and a registered busy flag.
// Define DEBOUNCE_LONG_PRESS_EN to add LONG_CYCLES and the long_pulse output.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int                NUM_CH        = 4,
    parameter int                SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int                CNT_W         = 20,
    parameter int                STABLE_CYCLES = DEF_STABLE_CYCLES_50MHZ_10MS,
`ifdef DEBOUNCE_LONG_PRESS_EN
    parameter int                LONG_CYCLES   = (1 << CNT_W) - 1,
`endif
    parameter logic [NUM_CH-1:0] RESET_VAL     = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] sig_in,
`ifdef DEBOUNCE_LONG_PRESS_EN
    output logic [NUM_CH-1:0] long_pulse,
`endif
    output logic [NUM_CH-1:0] sig_out,
    output logic [NUM_CH-1:0] rise_pulse,
    output logic [NUM_CH-1:0] fall_pulse,
    output logic              any_busy
);

    if (NUM_CH < 1 || SYNC_STAGES < 2 || STABLE_CYCLES < 2 ||
        clog2(64'(STABLE_CYCLES) + 64'd1) > CNT_W) begin : g_bad_param
        $error("debounce_bank: STABLE_CYCLES must be 2..2^CNT_W-1, SYNC_STAGES>=2, NUM_CH>=1");
    end
`ifdef DEBOUNCE_LONG_PRESS_EN
    if (LONG_CYCLES < 1 || clog2(64'(LONG_CYCLES) + 64'd1) > CNT_W) begin : g_bad_long
        $error("debounce_bank: LONG_CYCLES must be 1..2^CNT_W-1");
    end
`endif

    logic [NUM_CH-1:0] busy;
    logic              any_busy_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_ch #(
            .SYNC_STAGES  (SYNC_STAGES),
            .CNT_W        (CNT_W),
            .STABLE_CYCLES(STABLE_CYCLES),
`ifdef DEBOUNCE_LONG_PRESS_EN
            .LONG_CYCLES  (LONG_CYCLES),
`endif
            .RST_BIT      (RESET_VAL[i])
        ) u_ch (
            .clock  (clock),
            .reset_n(reset_n),
            .sig_i  (sig_in[i]),
`ifdef DEBOUNCE_LONG_PRESS_EN
            .long_o (long_pulse[i]),
`endif
            .sig_o  (sig_out[i]),
            .rise_o (rise_pulse[i]),
            .fall_o (fall_pulse[i]),
            .busy_o (busy[i])
        );
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) any_busy_q <= 1'b0;
        else          any_busy_q <= |busy;
    end

    assign any_busy = any_busy_q;

endmodule
